// File: rtl/out_drain_sched_pkg.sv
// Shared types and defaults for the output drain scheduler.
// State enum, default sizes and an index-width helper.
package out_pkg;

  typedef enum logic [1:0] {
    OS_IDLE,
    OS_RUN,
    OS_FLUSH
  } os_state_e;

  localparam int NCOLS_DEF = 8;
  localparam int DW_DEF    = 32;
  localparam int WPC_DEF   = 2;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = idx_w(NCOLS_DEF);

endpackage

// File: rtl/out_drain_sched_if.sv
// Host-facing valid/ready output stream of the drain scheduler.
// Carries m_data, m_col, m_last, m_valid (master) and m_ready (slave).
interface out_drain_sched_if
  import out_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = COL_W_DEF
) ();

  logic [DW-1:0] m_data;
  logic [CW-1:0] m_col;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;

  modport master (
    output m_data, m_col, m_last, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_col, m_last, m_valid,
    output m_ready
  );

endinterface

// File: rtl/out_drain_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr.
// In: req, ptr. Out: one-hot gnt, index idx, any, next pointer.
module rr_arbiter
  import out_pkg::*;
#(
  parameter int N = NCOLS_DEF,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any,
  output logic [W-1:0] ptr_nxt
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any = 1'b1;
        idx = W'((int'(ptr) + i) % N);
      end
    end
  end

  assign gnt = any ? (N'(1) << idx) : '0;

  // Pointer moves to the slot just past the winner.
  assign ptr_nxt = (int'(idx) == N - 1) ? '0 : idx + W'(1);

endmodule

// File: rtl/out_drain_sched.sv
// Frame drain scheduler: round-robin pops WORDS_PER_COL words per column.
// Ports: clk, rstn, start, col_data/col_valid/col_read, busy, done, m stream.
module out_drain_sched
  import out_pkg::*;
#(
  parameter int NCOLS         = NCOLS_DEF,
  parameter int DW            = DW_DEF,
  parameter int WORDS_PER_COL = WPC_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [NCOLS-1:0][DW-1:0]   col_data,
  input  logic [NCOLS-1:0]           col_valid,
  output logic [NCOLS-1:0]           col_read,
  output logic                       busy,
  output logic                       done,
  out_drain_sched_if.master          m
);

  localparam int CW  = idx_w(NCOLS);
  localparam int RW  = idx_w(WORDS_PER_COL + 1);
  localparam int TOT = NCOLS * WORDS_PER_COL;
  localparam int LW  = idx_w(TOT + 1);

  os_state_e                state;
  logic [CW-1:0]            ptr;
  logic [CW-1:0]            g_idx;
  logic [CW-1:0]            ptr_nxt;
  logic [NCOLS-1:0][RW-1:0] rem;
  logic [LW-1:0]            left;
  logic [NCOLS-1:0]         req;
  logic [NCOLS-1:0]         gnt;
  logic                     g_any;
  logic                     slot_free;
  logic                     grant;
  logic                     fin;

  always_comb begin
    req = '0;
    for (int c = 0; c < NCOLS; c++) begin
      req[c] = col_valid[c] && (rem[c] != '0);
    end
  end

  rr_arbiter #(
    .N (NCOLS),
    .W (CW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .idx     (g_idx),
    .any     (g_any),
    .ptr_nxt (ptr_nxt)
  );

  assign slot_free = !m.m_valid || m.m_ready;

  // rstn gates the pop so a mid-frame reset never pops a column.
  assign grant = rstn && (state == OS_RUN)
              && slot_free && g_any;

  assign col_read = grant ? gnt : '0;

  // Total-remaining counter: hitting zero marks the last word.
  assign fin = (left == LW'(1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= OS_IDLE;
      ptr       <= '0;
      rem       <= '0;
      left      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      m.m_data  <= '0;
      m.m_col   <= '0;
      m.m_last  <= 1'b0;
      m.m_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        OS_IDLE: begin
          if (start) begin
            rem   <= {NCOLS{RW'(WORDS_PER_COL)}};
            left  <= LW'(TOT);
            ptr   <= '0;
            busy  <= 1'b1;
            state <= OS_RUN;
          end
        end
        OS_RUN: begin
          if (m.m_valid && m.m_ready) begin
            m.m_valid <= 1'b0;
          end
          if (grant) begin
            m.m_data   <= col_data[g_idx];
            m.m_col    <= g_idx;
            m.m_valid  <= 1'b1;
            m.m_last   <= fin;
            rem[g_idx] <= rem[g_idx] - RW'(1);
            left       <= left - LW'(1);
            ptr        <= ptr_nxt;
            if (fin) begin
              state <= OS_FLUSH;
            end
          end
        end
        OS_FLUSH: begin
          if (m.m_valid && m.m_ready) begin
            m.m_valid <= 1'b0;
            m.m_last  <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= OS_IDLE;
          end
        end
        default: state <= OS_IDLE;
      endcase
    end
  end

endmodule
